// File: rtl/spike_noc_pkg.sv
// Shared spike-NoC types: packet width, end-of-timestep marker value and transmitter FSM states.
package spike_noc_pkg;
  localparam int SPIKE_ADDR_W = 12;
  localparam logic [SPIKE_ADDR_W-1:0] SPIKE_MARKER_ADDR = {SPIKE_ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    STALL,
    MARK
  } spike_tx_state_t;
endpackage

// File: rtl/spike_packet_transmitter_if.sv
// Spike-packet valid/ready channel: transmitter drives valid and address, the consumer drives ready.
interface spike_packet_transmitter_if #(
  parameter int ADDR_W = 12
);
  logic              packet_valid;
  logic              packet_ready;
  logic [ADDR_W-1:0] packet_source_address;

  modport master (
    output packet_valid,
    output packet_source_address,
    input  packet_ready
  );

  modport slave (
    input  packet_valid,
    input  packet_source_address,
    output packet_ready
  );
endinterface

// File: rtl/spike_fifo.sv
// Circular-buffer FIFO, head visible combinationally; push lands one edge after request.
// Push on full is accepted only with a same-cycle pop; pop on empty is ignored.
module spike_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end
endmodule

// File: rtl/spike_packet_transmitter.sv
// Captures spike flags on the rising edge of clear and emits one BASE_ADDR+k packet per fired neuron,
// first packet valid one edge after capture; stalls issue while the FIFO is full. Optional SPIKE_TX_TIMESTEP_MARKER_EN.
module spike_packet_transmitter
  import spike_noc_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = SPIKE_ADDR_W,
  parameter int BASE_ADDR   = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   clear,
  input  logic [NUM_NEURONS-1:0] spike,
  spike_packet_transmitter_if.master pkt,
  output logic                   busy,
  output logic                   overflow
);
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] MARKER = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);

  logic                   clear_dly_q;
  logic [NUM_NEURONS-1:0] pending_q, pending_next, pending_d, issue_oh;
  logic [IDX_W-1:0]       issue_idx;
  spike_tx_state_t        state_q;
  logic                   busy_q, overflow_q;

  logic                   fifo_full, fifo_empty, pop, can_push;
  logic                   capture, issue, mark_push, in_mark, enter_mark, lost, push, full_next;
  logic [CNT_W-1:0]       fifo_cnt, cnt_next;
  logic [ADDR_W-1:0]      push_dat;

  // Lowest set pending bit wins.
  assign issue_oh = pending_q & (~pending_q + NUM_NEURONS'(1));
  always_comb begin
    issue_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) issue_idx = IDX_W'(i);
    end
  end

  assign capture  = clear && !clear_dly_q;
  assign pop      = pkt.packet_valid && pkt.packet_ready;
  assign can_push = !fifo_full || pop;

`ifdef SPIKE_TX_TIMESTEP_MARKER_EN
  assign in_mark    = (state_q == MARK);
  assign enter_mark = (issue && (pending_next == '0)) ||
                      (capture && (spike == '0) && (pending_q == '0) && !in_mark);
`else
  assign in_mark    = 1'b0;
  assign enter_mark = 1'b0;
`endif

  // While the marker is owed, pending bits wait so the marker precedes the next timestep.
  assign issue     = !in_mark && (pending_q != '0) && can_push;
  assign mark_push = in_mark && can_push;
  assign push      = issue || mark_push;
  assign push_dat  = mark_push ? MARKER : (BASE + ADDR_W'(issue_idx));

  assign pending_next = issue ? (pending_q & ~issue_oh) : pending_q;
  assign lost         = capture && ((spike & pending_next) != '0);
  assign pending_d    = capture ? (pending_next | spike) : pending_next;

  assign cnt_next  = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
  assign full_next = (cnt_next == CNT_W'(FIFO_DEPTH));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      clear_dly_q <= 1'b0;
      pending_q   <= '0;
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clear_dly_q <= clear;
      pending_q   <= pending_d;
      if (lost) overflow_q <= 1'b1;
      if ((in_mark && !mark_push) || enter_mark) begin
        state_q <= MARK;
        busy_q  <= 1'b1;
      end else begin
        busy_q <= (pending_d != '0) || (cnt_next != '0);
        if (pending_d == '0)  state_q <= IDLE;
        else if (full_next)   state_q <= STALL;
        else                  state_q <= SCAN;
      end
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign pkt.packet_valid = !fifo_empty;

  spike_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (pkt.packet_source_address),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );
endmodule

// File: tb/tb_spike_packet_transmitter.sv
// Directed bench with an expected-packet scoreboard drained by a negedge monitor.
module tb_spike_packet_transmitter;
  import spike_noc_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       clear;
  logic [9:0] spike;
  logic       busy, overflow;

  int nchk = 0;
  int nerr = 0;
  logic [11:0] exp_q[$];

  spike_packet_transmitter_if #(.ADDR_W(12)) pkt ();

  spike_packet_transmitter #(
    .NUM_NEURONS (10),
    .ADDR_W      (12),
    .BASE_ADDR   (0),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .clear    (clear),
    .spike    (spike),
    .pkt      (pkt),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Accepted transfers are sampled mid-cycle, ahead of the edge that consumes them.
  always @(negedge CLK) begin
    if (RESET_N && pkt.packet_valid && pkt.packet_ready) begin
      nchk++;
      assert (exp_q.size() != 0) else begin
        nerr++;
        $error("FAIL pkt_unexpected observed=%0h expected=none", pkt.packet_source_address);
      end
      if (exp_q.size() != 0) begin
        logic [11:0] e;
        e = exp_q.pop_front();
        nchk++;
        assert (pkt.packet_source_address === e) else begin
          nerr++;
          $error("FAIL pkt_addr observed=%0h expected=%0h", pkt.packet_source_address, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [9:0] s, input bit push_exp);
    clear = 1'b1;
    spike = s;
    if (push_exp) for (int i = 0; i < 10; i++) if (s[i]) exp_q.push_back(12'(i));
    tick();
    clear = 1'b0;
    spike = '0;
  endtask

  task automatic mark_exp();
`ifdef SPIKE_TX_TIMESTEP_MARKER_EN
    exp_q.push_back(12'hFFF);
`endif
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    RESET_N = 1'b0;
    clear = 1'b0;
    spike = '0;
    pkt.packet_ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", pkt.packet_valid, 0);
    chk("rst_addr", pkt.packet_source_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    RESET_N = 1'b1;
    tick();

    // Single spike on neuron 6.
    pkt.packet_ready = 1'b1;
    capture(10'b0001000000, 1'b1);
    mark_exp();
    chk("single_busy_n", busy, 1);
    chk("single_valid_n", pkt.packet_valid, 0);
    tick();
    chk("single_valid_n1", pkt.packet_valid, 1);
    chk("single_addr_n1", pkt.packet_source_address, 6);
`ifndef SPIKE_TX_TIMESTEP_MARKER_EN
    tick();
    chk("single_busy_n2", busy, 0);
    chk("single_valid_n2", pkt.packet_valid, 0);
`endif
    wait_drain("single");

    // All neurons at full throughput.
    capture(10'h3FF, 1'b1);
    mark_exp();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("all_valid_%0d", i), pkt.packet_valid, 1);
    end
`ifndef SPIKE_TX_TIMESTEP_MARKER_EN
    tick();
    chk("all_valid_end", pkt.packet_valid, 0);
`endif
    wait_drain("all");
    chk("all_ovf", overflow, 0);

    // Backpressure: FIFO fills with 0..3 and the head holds.
    pkt.packet_ready = 1'b0;
    capture(10'h3FF, 1'b1);
    mark_exp();
    repeat (6) tick();
    chk("bp_state", 32'(dut.state_q), 32'(STALL));
    chk("bp_valid", pkt.packet_valid, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_head_%0d", i), pkt.packet_source_address, 0);
    end
    pkt.packet_ready = 1'b1;
    wait_drain("bp");
    chk("bp_ovf", overflow, 0);

    // Overflow: bit 1 re-fired while still pending behind a full FIFO.
    pkt.packet_ready = 1'b0;
    capture(10'b0000111100, 1'b1);
    mark_exp();
    repeat (5) tick();
    capture(10'b0000000011, 1'b1);
    chk("ovf_before", overflow, 0);
    tick();
    capture(10'b0000000010, 1'b0);
    mark_exp();
    chk("ovf_set", overflow, 1);
    pkt.packet_ready = 1'b1;
    wait_drain("ovf");
    chk("ovf_sticky", overflow, 1);
    repeat (3) tick();
    chk("ovf_quiet", pkt.packet_valid, 0);

    // Reset after two of five packets.
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
    tick();
    chk("rst2_ovf_clr", overflow, 0);
    capture(10'b0000011111, 1'b1);
    mark_exp();
    repeat (3) tick();
    chk("mid_left", exp_q.size(), 3 + ((exp_q.size() > 3) ? 1 : 0));
    RESET_N = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_valid", pkt.packet_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_addr", pkt.packet_source_address, 0);
    tick();
    RESET_N = 1'b1;
    repeat (10) tick();
    chk("post_valid", pkt.packet_valid, 0);
    chk("post_busy", busy, 0);

`ifdef SPIKE_TX_TIMESTEP_MARKER_EN
    // Timestep markers.
    capture(10'b1000000001, 1'b1);
    mark_exp();
    wait_drain("mark_pair");
    capture(10'b0000000000, 1'b0);
    mark_exp();
    chk("mark_busy", busy, 1);
    wait_drain("mark_lone");
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
